alu_seq: RTL and testbench

Parametrised, registered successor to the team's combinational lab ALU. Accepts an operation and two unsigned `N`-bit operands on a `start` strobe, computes add/sub/and/or in one cycle, and computes a multi-cycle shift-add multiply. Results and flags are held in registers until the next operation. Sits between the operand-entry/button logic and the 7-segment display driver.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul.sv | 55 +++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and state encodings shared by the registered ALU and
// the operand-entry/button-decode logic.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_MUL = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Raw opcode values for logic that drives a plain 3-bit bus.
    localparam logic [2:0] OPC_ADD = OP_ADD;
    localparam logic [2:0] OPC_SUB = OP_SUB;
    localparam logic [2:0] OPC_AND = OP_AND;
    localparam logic [2:0] OPC_OR  = OP_OR;
    localparam logic [2:0] OPC_MUL = OP_MUL;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: N-step right-shifting shift-add multiplier.
// load latches the operands and clears the high half of the accumulator;
// each step adds the multiplicand when the current multiplier LSB is set
// and shifts the accumulator right by one. `product` is the accumulator
// value produced by the current step, so when step & last it is the final
// 2N-bit product.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           last,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  count;
    logic [N-1:0]   addend;
    logic [N:0]     sum;

    // One shift-add step: the carry of the high-half add shifts into the MSB.
    always_comb begin
        addend  = acc[0] ? mcand : '0;
        sum     = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
        product = {sum, acc[N-1:1]};
    end

    assign last = (count == CW'(N - 1));

    // Operand latch, accumulator and iteration counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            mcand <= a;
            acc   <= {{N{1'b0}}, b};
            count <= '0;
        end else if (step) begin
            acc   <= product;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle add/sub/and/or and an optional
// multi-cycle multiply. Build option: define ALU_SEQ_MUL_EN to compile in
// the multiplier, the RUN state and the iteration counter; without it MUL
// is reported as an invalid opcode with latency 1.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] numero_a,
    input  logic [N-1:0] numero_b,
    output logic [N-1:0] resultado,
    output logic [N-1:0] resultado_hi,
    output logic         overflow,
    output logic         underflow,
    output logic         zero,
    output logic         valid_result,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]     state, state_nxt;
    logic [N-1:0]   res_nxt, hi_nxt, res_hi_q;
    logic           ovf_nxt, unf_nxt, vld_nxt;
    logic [N:0]     sum_ext, diff_ext;
    logic [N-1:0]   alu_res;
    logic           alu_ovf, alu_unf, alu_ok;
    logic           op_is_mul, mul_load, mul_last;
    logic [2*N-1:0] mul_product;

`ifdef ALU_SEQ_MUL_EN
    assign op_is_mul = (op == OPC_MUL);
    assign busy      = (state == RUN);

    alu_seq_mul #(.N(N)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_load),
        .step    (state == RUN),
        .a       (numero_a),
        .b       (numero_b),
        .last    (mul_last),
        .product (mul_product)
    );
`else
    // RUN is unreachable: MUL falls through to the invalid-op path.
    assign op_is_mul   = 1'b0;
    assign busy        = 1'b0;
    assign mul_last    = 1'b0;
    assign mul_product = '0;
`endif

    assign resultado_hi = res_hi_q;
    assign done         = (state == DONE);
    assign zero         = (resultado == '0);

    // Single-cycle datapath on the live operands; registered at the start edge.
    always_comb begin
        sum_ext  = {1'b0, numero_a} + {1'b0, numero_b};
        diff_ext = {1'b0, numero_a} - {1'b0, numero_b};
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_unf  = 1'b0;
        alu_ok   = 1'b1;
        case (op)
            OPC_ADD: begin
                alu_res = sum_ext[N-1:0];
                alu_ovf = sum_ext[N];
            end
            OPC_SUB: begin
                alu_res = diff_ext[N-1:0];
                alu_unf = diff_ext[N];
            end
            OPC_AND: alu_res = numero_a & numero_b;
            OPC_OR:  alu_res = numero_a | numero_b;
            default: alu_ok  = 1'b0;
        endcase
    end

    // FSM next state and next values of the held result/flag registers.
    always_comb begin
        state_nxt = state;
        res_nxt   = resultado;
        hi_nxt    = res_hi_q;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;
        vld_nxt   = valid_result;
        mul_load  = 1'b0;
        if (state == RUN) begin
            if (mul_last) begin
                state_nxt = DONE;
                res_nxt   = mul_product[N-1:0];
                hi_nxt    = mul_product[2*N-1:N];
                ovf_nxt   = |mul_product[2*N-1:N];
                unf_nxt   = 1'b0;
                vld_nxt   = ~(|mul_product[2*N-1:N]);
            end
        end else if (start && op_is_mul) begin
            state_nxt = RUN;
            mul_load  = 1'b1;
        end else if (start) begin
            state_nxt = DONE;
            res_nxt   = alu_res;
            hi_nxt    = '0;
            ovf_nxt   = alu_ovf;
            unf_nxt   = alu_unf;
            vld_nxt   = alu_ok & ~(alu_ovf | alu_unf);
        end else if (state == DONE) begin
            state_nxt = IDLE;
        end
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            resultado    <= '0;
            res_hi_q     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            valid_result <= 1'b1;
        end else begin
            state        <= state_nxt;
            resultado    <= res_nxt;
            res_hi_q     <= hi_nxt;
            overflow     <= ovf_nxt;
            underflow    <= unf_nxt;
            valid_result <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned N = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] numero_a, numero_b;
    logic [N-1:0] resultado, resultado_hi;
    logic         overflow, underflow, zero, valid_result, busy, done;

    int checks = 0;
    int errors = 0;

    alu_seq #(.N(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .numero_a     (numero_a),
        .numero_b     (numero_b),
        .resultado    (resultado),
        .resultado_hi (resultado_hi),
        .overflow     (overflow),
        .underflow    (underflow),
        .zero         (zero),
        .valid_result (valid_result),
        .busy         (busy),
        .done         (done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        longint unsigned res;
        longint unsigned hi;
        bit              ovf;
        bit              unf;
        bit              vld;
    } exp_t;

    typedef struct {
        logic [2:0]      op;
        longint unsigned a;
        longint unsigned b;
        exp_t            e;
    } vec_t;

    function automatic exp_t model(input longint unsigned o, input longint unsigned a,
                                   input longint unsigned b);
        exp_t            e;
        longint unsigned full;
        longint unsigned p;
        full = 64'd1 << N;
        e = '{0, 0, 1'b0, 1'b0, 1'b0};
        case (o)
            0: begin
                p     = a + b;
                e.res = p % full;
                e.ovf = (p >= full);
            end
            1: begin
                e.unf = (a < b);
                e.res = (a + full - b) % full;
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: if (MUL_EN) begin
                p     = a * b;
                e.res = p % full;
                e.hi  = p / full;
                e.ovf = (e.hi != 0);
            end
            default: ;
        endcase
        e.vld = (o <= 3 || (o == 4 && MUL_EN)) && !e.ovf && !e.unf;
        return e;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, " resultado"},    64'(resultado), 0);
        chk({nm, " resultado_hi"}, 64'(resultado_hi), 0);
        chk({nm, " overflow"},     64'(overflow), 0);
        chk({nm, " underflow"},    64'(underflow), 0);
        chk({nm, " zero"},         64'(zero), 1);
        chk({nm, " valid_result"}, 64'(valid_result), 1);
        chk({nm, " busy"},         64'(busy), 0);
        chk({nm, " done"},         64'(done), 0);
    endtask

    // Issue one op, scramble the inputs after the start edge, measure latency
    // and busy cycles, compare the registered outputs, then confirm they hold.
    task automatic do_op(input logic [2:0] o, input longint unsigned a, input longint unsigned b,
                         input exp_t e, input string nm);
        int lat, busy_cnt, lat_exp;
        lat_exp = (o == 3'd4 && MUL_EN) ? int'(N) + 1 : 1;
        @(negedge clk);
        start = 1'b1; op = o; numero_a = N'(a); numero_b = N'(b);
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); numero_a = N'($urandom); numero_b = N'($urandom);
        lat = 1; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"},      64'(lat), 64'(lat_exp));
        chk({nm, " busy cycles"},  64'(busy_cnt), 64'(lat_exp - 1));
        chk({nm, " busy at done"}, 64'(busy), 0);
        chk({nm, " resultado"},    64'(resultado), e.res);
        chk({nm, " resultado_hi"}, 64'(resultado_hi), e.hi);
        chk({nm, " overflow"},     64'(overflow), 64'(e.ovf));
        chk({nm, " underflow"},    64'(underflow), 64'(e.unf));
        chk({nm, " valid_result"}, 64'(valid_result), 64'(e.vld));
        chk({nm, " zero"},         64'(zero), 64'(e.res == 0));
        @(posedge clk); #1;
        chk({nm, " done pulse"},   64'(done), 0);
        chk({nm, " hold"},         64'(resultado), e.res);
    endtask

    vec_t vecs[11];

    initial begin
        int cnt;
        exp_t e;
        longint unsigned ra, rb, ro;

        // Directed vectors; N = 8.
        vecs[0]  = '{3'd0, 200, 100, '{44, 0, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{3'd1, 5, 7,     '{254, 0, 1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{3'd1, 7, 7,     '{0, 0, 1'b0, 1'b0, 1'b1}};
        vecs[3]  = '{3'd2, 'hF0, 'h3C, '{'h30, 0, 1'b0, 1'b0, 1'b1}};
        vecs[4]  = '{3'd3, 'hF0, 'h3C, '{'hFC, 0, 1'b0, 1'b0, 1'b1}};
        vecs[5]  = '{3'd6, 3, 4,     '{0, 0, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{3'd0, 255, 1,   '{0, 0, 1'b1, 1'b0, 1'b0}};
        vecs[7]  = '{3'd7, 9, 9,     '{0, 0, 1'b0, 1'b0, 1'b0}};
`ifdef ALU_SEQ_MUL_EN
        vecs[8]  = '{3'd4, 15, 17,   '{255, 0, 1'b0, 1'b0, 1'b1}};
        vecs[9]  = '{3'd4, 16, 16,   '{0, 1, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{3'd4, 255, 255, '{1, 254, 1'b1, 1'b0, 1'b0}};
`else
        vecs[8]  = '{3'd4, 15, 17,   '{0, 0, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{3'd4, 16, 16,   '{0, 0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{3'd4, 255, 255, '{0, 0, 1'b0, 1'b0, 1'b0}};
`endif

        reset_n = 1'b0; start = 1'b0; op = '0; numero_a = '0; numero_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

        // Back-to-back AND then OR: done stays high, results on successive cycles.
        @(negedge clk);
        start = 1'b1; op = 3'd2; numero_a = 8'hF0; numero_b = 8'h3C;
        @(posedge clk); #1;
        chk("b2b and done", 64'(done), 1);
        chk("b2b and res",  64'(resultado), 'h30);
        @(negedge clk);
        op = 3'd3;
        @(posedge clk); #1;
        chk("b2b or done",  64'(done), 1);
        chk("b2b or res",   64'(resultado), 'hFC);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle done", 64'(done), 0);
        chk("b2b hold res",  64'(resultado), 'hFC);

        // ADD pulsed during a multiply is dropped (without the multiplier the
        // MUL completes at once, so the ADD becomes the latest op).
        @(negedge clk);
        start = 1'b1; op = 3'd4; numero_a = 8'd15; numero_b = 8'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd0; numero_a = 8'd1; numero_b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while ((busy || done) && cnt < 40);
        chk("drop start settle", 64'(cnt < 40), 1);
        chk("drop start res",    64'(resultado), MUL_EN ? 255 : 2);
        chk("drop start hi",     64'(resultado_hi), 0);
        chk("drop start valid",  64'(valid_result), 1);

        // Reset asserted in the 4th RUN cycle: immediate reset values, no done.
        do_op(3'd0, 200, 100, model(0, 200, 100), "pre-abort add");
        @(negedge clk);
        start = 1'b1; op = 3'd4; numero_a = 8'd16; numero_b = 8'd16;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_values("abort");
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < int'(N) + 4; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("abort no done", 64'(cnt), 0);
        chk("abort res held", 64'(resultado), 0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 120; i++) begin
            ro = longint'($urandom_range(0, 7));
            ra = longint'($urandom_range(0, 255));
            rb = (i % 8 == 0) ? ra : longint'($urandom_range(0, 255));
            e  = model(ro, ra, rb);
            do_op(3'(ro), ra, rb, e, $sformatf("rnd%0d op%0d %0d,%0d", i, ro, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
